// File: rtl/m68k_bus_target_if.sv
// m68k_bus_target_if
//   Bundles the 68000 bus signals seen by a bus responder.
//   master modport : drives address, function code, strobes, RW and write data;
//                    observes read data, drive enable, DTACK_n, BERR_n and IPL_n.
//   slave modport  : the responder side (m68k_bus_target), the mirror image.
//   Clock and reset are not part of the bundle; they stay plain module ports.
interface m68k_bus_target_if;
    logic [23:1] M68K_A;
    logic [2:0]  M68K_FC;
    logic        M68K_AS_n;
    logic        M68K_UDS_n;
    logic        M68K_LDS_n;
    logic        M68K_RW;
    logic [15:0] M68K_D_IN;
    logic [15:0] M68K_D_OUT;
    logic        M68K_D_OE;
    logic        M68K_DTACK_n;
    logic        M68K_BERR_n;
    logic [2:0]  M68K_IPL_n;

    modport master (
        output M68K_A, M68K_FC, M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW, M68K_D_IN,
        input  M68K_D_OUT, M68K_D_OE, M68K_DTACK_n, M68K_BERR_n, M68K_IPL_n
    );

    modport slave (
        input  M68K_A, M68K_FC, M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW, M68K_D_IN,
        output M68K_D_OUT, M68K_D_OE, M68K_DTACK_n, M68K_BERR_n, M68K_IPL_n
    );
endinterface

// File: rtl/m68k_bus_target.sv
// m68k_bus_target
//   68000 bus responder. Registers the bus inputs once, decodes a cycle against
//   a word window at BASE_ADDR, serves a small register file (ID word, RAM,
//   IPL control word) and terminates with DTACK_n, BERR_n or silence.
// Ports
//   M68K_CLK      bus clock, all state on the rising edge
//   M68K_RESET_n  asynchronous active-low reset
//   bus           slave side of m68k_bus_target_if: A[23:1], FC, AS_n, UDS_n,
//                 LDS_n, RW, D_IN in; D_OUT, D_OE, DTACK_n, BERR_n, IPL_n out
module m68k_bus_target #(
    parameter logic [23:0] BASE_ADDR   = 24'hE80000,
    parameter int          ADDR_BITS   = 6,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] ID_VALUE    = 16'h5053
) (
    input logic              M68K_CLK,
    input logic              M68K_RESET_n,
    m68k_bus_target_if.slave bus
);

    localparam int                   NWORDS    = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] ID_IDX    = '0;
    localparam logic [ADDR_BITS-1:0] IPL_IDX   = '1;
    localparam logic [3:0]           WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_ERR,
        ST_IGNORE
    } state_e;

    // Registered bus inputs
    logic                 asN_q, udsN_q, ldsN_q, rw_q;
    logic [23:1]          addr_q;
    logic [2:0]           fc_q;
    logic [15:0]          dIn_q;

    // Cycle context and FSM
    state_e               state_q, state_d;
    logic [3:0]           waitCnt_q, waitCnt_d;
    logic [ADDR_BITS-1:0] cycIdx_q, cycIdx_d;
    logic                 cycRw_q, cycRw_d;
    logic                 cycUds_q, cycUds_d;
    logic                 cycLds_q, cycLds_d;

    // Registered outputs and IPL control
    logic                 dtackN_q, dtackN_d;
    logic                 berrN_q, berrN_d;
    logic                 dOe_q, dOe_d;
    logic [15:0]          dOut_q, dOut_d;
    logic [2:0]           iplLevel_q, iplLevel_d;

    logic [1:0]           ramWe;
    logic [15:0]          readData;
    logic                 inWindow;
    logic [ADDR_BITS-1:0] addrIdx;
    logic [15:0]          ram [0:NWORDS-1];

    // Single input register stage; everything downstream uses these copies,
    // so the strobes are idle (high) out of reset.
    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            asN_q  <= 1'b1;
            udsN_q <= 1'b1;
            ldsN_q <= 1'b1;
            rw_q   <= 1'b1;
            addr_q <= '0;
            fc_q   <= '0;
            dIn_q  <= '0;
        end else begin
            asN_q  <= bus.M68K_AS_n;
            udsN_q <= bus.M68K_UDS_n;
            ldsN_q <= bus.M68K_LDS_n;
            rw_q   <= bus.M68K_RW;
            addr_q <= bus.M68K_A;
            fc_q   <= bus.M68K_FC;
            dIn_q  <= bus.M68K_D_IN;
        end
    end

    // The window is aligned to its size, so the decode is a plain compare of
    // the address bits above the word index.
    assign inWindow = (addr_q[23:ADDR_BITS+1] == BASE_ADDR[23:ADDR_BITS+1]);
    assign addrIdx  = addr_q[ADDR_BITS:1];

    // Read mux over the latched word index: ID, IPL control, else RAM.
    always_comb begin
        readData = ram[cycIdx_q];
        if (cycIdx_q == ID_IDX) begin
            readData = ID_VALUE;
        end else if (cycIdx_q == IPL_IDX) begin
            readData = {13'd0, iplLevel_q};
        end
    end

    // Next-state and output logic. Outputs change only on state transitions,
    // so the ACK entry edge is the single point where DTACK_n, read data and
    // the write commit happen together; the write cannot repeat while in ACK.
    always_comb begin
        state_d    = state_q;
        waitCnt_d  = waitCnt_q;
        cycIdx_d   = cycIdx_q;
        cycRw_d    = cycRw_q;
        cycUds_d   = cycUds_q;
        cycLds_d   = cycLds_q;
        dtackN_d   = dtackN_q;
        berrN_d    = berrN_q;
        dOe_d      = dOe_q;
        dOut_d     = dOut_q;
        iplLevel_d = iplLevel_q;
        ramWe      = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (!asN_q && (!udsN_q || !ldsN_q)) begin
                    cycIdx_d = addrIdx;
                    cycRw_d  = rw_q;
                    cycUds_d = !udsN_q;
                    cycLds_d = !ldsN_q;
                    if ((fc_q == 3'b111) || !inWindow) begin
                        state_d = ST_IGNORE;
                    end else if (!rw_q && (addrIdx == ID_IDX)) begin
                        state_d = ST_ERR;
                        berrN_d = 1'b0;
                    end else begin
                        state_d   = ST_WAIT;
                        waitCnt_d = WAIT_LOAD;
                    end
                end
            end

            ST_WAIT: begin
                if (asN_q) begin
                    // Master gave up before we acknowledged: drop the cycle.
                    state_d = ST_IDLE;
                end else if (waitCnt_q == 4'd0) begin
                    state_d  = ST_ACK;
                    dtackN_d = 1'b0;
                    if (cycRw_q) begin
                        dOe_d  = 1'b1;
                        dOut_d = readData;
                    end else if (cycIdx_q == IPL_IDX) begin
                        // Level lives in the low byte; an upper-lane-only write has no effect.
                        if (cycLds_q) begin
                            iplLevel_d = dIn_q[2:0];
                        end
                    end else begin
                        ramWe = {cycUds_q, cycLds_q};
                    end
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end
            end

            ST_ACK, ST_ERR, ST_IGNORE: begin
                if (asN_q) begin
                    state_d  = ST_IDLE;
                    dtackN_d = 1'b1;
                    berrN_d  = 1'b1;
                    dOe_d    = 1'b0;
                    dOut_d   = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, cycle context and output registers.
    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            state_q    <= ST_IDLE;
            waitCnt_q  <= '0;
            cycIdx_q   <= '0;
            cycRw_q    <= 1'b1;
            cycUds_q   <= 1'b0;
            cycLds_q   <= 1'b0;
            dtackN_q   <= 1'b1;
            berrN_q    <= 1'b1;
            dOe_q      <= 1'b0;
            dOut_q     <= '0;
            iplLevel_q <= '0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            cycIdx_q   <= cycIdx_d;
            cycRw_q    <= cycRw_d;
            cycUds_q   <= cycUds_d;
            cycLds_q   <= cycLds_d;
            dtackN_q   <= dtackN_d;
            berrN_q    <= berrN_d;
            dOe_q      <= dOe_d;
            dOut_q     <= dOut_d;
            iplLevel_q <= iplLevel_d;
        end
    end

    // Byte-lane RAM. Not reset; a reset mid-cycle returns the FSM to IDLE,
    // which forces ramWe low, so no write can land afterwards.
    always_ff @(posedge M68K_CLK) begin
        if (ramWe[1]) begin
            ram[cycIdx_q][15:8] <= dIn_q[15:8];
        end
        if (ramWe[0]) begin
            ram[cycIdx_q][7:0] <= dIn_q[7:0];
        end
    end

    assign bus.M68K_D_OUT   = dOut_q;
    assign bus.M68K_D_OE    = dOe_q;
    assign bus.M68K_DTACK_n = dtackN_q;
    assign bus.M68K_BERR_n  = berrN_q;
    assign bus.M68K_IPL_n   = ~iplLevel_q;

endmodule

// File: tb/tb_m68k_bus_target.sv
// tb_m68k_bus_target
//   Directed bench for m68k_bus_target (BASE 0xE80000, 64 words, 2 wait states).
//   Each bus cycle pushes its expected termination/latency/data to a queue;
//   the result observed on the bus is popped and compared afterwards.
module tb_m68k_bus_target;

    localparam int TERM_NONE = 0;
    localparam int TERM_ACK  = 1;
    localparam int TERM_BERR = 2;
    // Strobe registered (1) + start decision (1) + WAIT_STATES + ACK edge (1)
    localparam int ACK_LAT   = 5;
    localparam int BERR_LAT  = 2;

    typedef struct {
        string       tag;
        int          term;
        logic [15:0] data;
        bit          checkData;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rstN;

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;

    int          obsTerm;
    int          obsLat;
    logic [15:0] obsData;
    logic        obsOe;
    logic        relOk;

    m68k_bus_target_if bus ();

    m68k_bus_target #(
        .BASE_ADDR   (24'hE80000),
        .ADDR_BITS   (6),
        .WAIT_STATES (2),
        .ID_VALUE    (16'h5053)
    ) dut (
        .M68K_CLK     (clk),
        .M68K_RESET_n (rstN),
        .bus          (bus.slave)
    );

    // Free-running 100 MHz bus clock
    always #5 clk = ~clk;

    // Hard stop in case something hangs
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Run one complete bus cycle and record what the responder did.
    task automatic runCycle(input logic [23:0] byteAddr, input logic [2:0] fc, input logic rw,
                            input logic udsN, input logic ldsN, input logic [15:0] wdata);
        logic [23:0] a;
        a = byteAddr;
        @(negedge clk);
        bus.M68K_A     = a[23:1];
        bus.M68K_FC    = fc;
        bus.M68K_RW    = rw;
        bus.M68K_D_IN  = wdata;
        bus.M68K_UDS_n = udsN;
        bus.M68K_LDS_n = ldsN;
        bus.M68K_AS_n  = 1'b0;
        obsTerm = TERM_NONE;
        obsLat  = -1;
        obsData = 'x;
        obsOe   = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.M68K_DTACK_n !== 1'b1 || bus.M68K_BERR_n !== 1'b1) begin
                obsTerm = ((bus.M68K_DTACK_n === 1'b0) ? TERM_ACK : 0) +
                          ((bus.M68K_BERR_n === 1'b0) ? TERM_BERR : 0);
                obsLat  = k;
                obsData = bus.M68K_D_OUT;
                obsOe   = bus.M68K_D_OE;
                break;
            end
        end
        @(negedge clk);
        bus.M68K_AS_n  = 1'b1;
        bus.M68K_UDS_n = 1'b1;
        bus.M68K_LDS_n = 1'b1;
        bus.M68K_RW    = 1'b1;
        repeat (3) @(negedge clk);
        relOk = (bus.M68K_DTACK_n === 1'b1) && (bus.M68K_BERR_n === 1'b1) && (bus.M68K_D_OE === 1'b0);
    endtask

    task automatic checkOutput();
        exp_t e;
        e = sbQ.pop_front();
        checkVal({e.tag, "_term"}, obsTerm, e.term);
        if (e.lat >= 0) checkVal({e.tag, "_latency"}, obsLat, e.lat);
        if (e.checkData) begin
            checkVal({e.tag, "_data"}, {16'd0, obsData}, {16'd0, e.data});
            checkVal({e.tag, "_oe"}, {31'd0, obsOe}, 32'd1);
        end
        checkVal({e.tag, "_release"}, {31'd0, relOk}, 32'd1);
    endtask

    task automatic applyStimulus(input string tag, input logic [23:0] byteAddr, input logic [2:0] fc,
                                 input logic rw, input logic udsN, input logic ldsN, input logic [15:0] wdata,
                                 input int expTerm, input logic [15:0] expData, input bit checkData, input int expLat);
        exp_t e;
        e.tag       = tag;
        e.term      = expTerm;
        e.data      = expData;
        e.checkData = checkData;
        e.lat       = expLat;
        sbQ.push_back(e);
        runCycle(byteAddr, fc, rw, udsN, ldsN, wdata);
        checkOutput();
    endtask

    initial begin
        bit sawTerm;
        bit reached;

        bus.M68K_A     = '0;
        bus.M68K_FC    = 3'b101;
        bus.M68K_AS_n  = 1'b1;
        bus.M68K_UDS_n = 1'b1;
        bus.M68K_LDS_n = 1'b1;
        bus.M68K_RW    = 1'b1;
        bus.M68K_D_IN  = '0;
        rstN = 1'b1;
        #1 rstN = 1'b0;
        repeat (3) @(negedge clk);

        checkVal("reset_dtack", {31'd0, bus.M68K_DTACK_n}, 32'd1);
        checkVal("reset_berr",  {31'd0, bus.M68K_BERR_n},  32'd1);
        checkVal("reset_oe",    {31'd0, bus.M68K_D_OE},    32'd0);
        checkVal("reset_dout",  {16'd0, bus.M68K_D_OUT},   32'd0);
        checkVal("reset_ipl",   {29'd0, bus.M68K_IPL_n},   32'd7);

        rstN = 1'b1;
        repeat (2) @(negedge clk);

        // ID word read, full latency check
        applyStimulus("id_read", 24'hE80000, 3'b110, 1'b1, 1'b0, 1'b0, 16'h0000, TERM_ACK, 16'h5053, 1'b1, ACK_LAT);

        // Lane writes
        applyStimulus("w2_full", 24'hE80004, 3'b101, 1'b0, 1'b0, 1'b0, 16'h1111, TERM_ACK, 16'h0, 1'b0, ACK_LAT);
        applyStimulus("w2_uds",  24'hE80004, 3'b101, 1'b0, 1'b0, 1'b1, 16'hA5C3, TERM_ACK, 16'h0, 1'b0, ACK_LAT);
        applyStimulus("r2",      24'hE80004, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, TERM_ACK, 16'hA511, 1'b1, ACK_LAT);
        applyStimulus("w3_full", 24'hE80006, 3'b101, 1'b0, 1'b0, 1'b0, 16'h2222, TERM_ACK, 16'h0, 1'b0, ACK_LAT);
        applyStimulus("w3_lds",  24'hE80006, 3'b101, 1'b0, 1'b1, 1'b0, 16'h7788, TERM_ACK, 16'h0, 1'b0, ACK_LAT);
        applyStimulus("r3",      24'hE80006, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, TERM_ACK, 16'h2288, 1'b1, ACK_LAT);

        // IPL control word
        applyStimulus("ipl_w5", 24'hE8007E, 3'b101, 1'b0, 1'b0, 1'b0, 16'h0005, TERM_ACK, 16'h0, 1'b0, ACK_LAT);
        checkVal("ipl_after_5", {29'd0, bus.M68K_IPL_n}, 32'd2);
        applyStimulus("ipl_r5", 24'hE8007E, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, TERM_ACK, 16'h0005, 1'b1, ACK_LAT);
        applyStimulus("ipl_uds", 24'hE8007E, 3'b101, 1'b0, 1'b0, 1'b1, 16'h0707, TERM_ACK, 16'h0, 1'b0, ACK_LAT);
        checkVal("ipl_after_uds", {29'd0, bus.M68K_IPL_n}, 32'd2);
        applyStimulus("ipl_w0", 24'hE8007E, 3'b101, 1'b0, 1'b0, 1'b0, 16'h0000, TERM_ACK, 16'h0, 1'b0, ACK_LAT);
        checkVal("ipl_after_0", {29'd0, bus.M68K_IPL_n}, 32'd7);
        applyStimulus("ipl_wff", 24'hE8007E, 3'b101, 1'b0, 1'b0, 1'b0, 16'hFFFF, TERM_ACK, 16'h0, 1'b0, ACK_LAT);
        checkVal("ipl_after_ff", {29'd0, bus.M68K_IPL_n}, 32'd0);
        applyStimulus("ipl_r7", 24'hE8007E, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, TERM_ACK, 16'h0007, 1'b1, ACK_LAT);

        // Bus error and ignored cycles
        applyStimulus("id_write",  24'hE80000, 3'b101, 1'b0, 1'b0, 1'b0, 16'h1234, TERM_BERR, 16'h0, 1'b0, BERR_LAT);
        applyStimulus("out_win",   24'hE90000, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, TERM_NONE, 16'h0, 1'b0, -1);
        applyStimulus("cpu_space", 24'hE80002, 3'b111, 1'b1, 1'b0, 1'b0, 16'h0000, TERM_NONE, 16'h0, 1'b0, -1);
        applyStimulus("after_ign", 24'hE80004, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, TERM_ACK, 16'hA511, 1'b1, ACK_LAT);

        // Abort: AS_n released one clock after the start decision
        applyStimulus("w5_full", 24'hE8000A, 3'b101, 1'b0, 1'b0, 1'b0, 16'h1234, TERM_ACK, 16'h0, 1'b0, ACK_LAT);
        @(negedge clk);
        bus.M68K_A     = 23'h740005;
        bus.M68K_FC    = 3'b101;
        bus.M68K_RW    = 1'b0;
        bus.M68K_D_IN  = 16'hBEEF;
        bus.M68K_UDS_n = 1'b0;
        bus.M68K_LDS_n = 1'b0;
        bus.M68K_AS_n  = 1'b0;
        sawTerm = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.M68K_DTACK_n !== 1'b1 || bus.M68K_BERR_n !== 1'b1) sawTerm = 1'b1;
        end
        bus.M68K_AS_n  = 1'b1;
        bus.M68K_UDS_n = 1'b1;
        bus.M68K_LDS_n = 1'b1;
        bus.M68K_RW    = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.M68K_DTACK_n !== 1'b1 || bus.M68K_BERR_n !== 1'b1) sawTerm = 1'b1;
        end
        checkVal("abort_no_term", {31'd0, sawTerm}, 32'd0);
        applyStimulus("abort_r5", 24'hE8000A, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000, TERM_ACK, 16'h1234, 1'b1, ACK_LAT);

        // Reset while the responder holds DTACK_n low
        @(negedge clk);
        bus.M68K_A     = 23'h740005;
        bus.M68K_RW    = 1'b1;
        bus.M68K_UDS_n = 1'b0;
        bus.M68K_LDS_n = 1'b0;
        bus.M68K_AS_n  = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.M68K_DTACK_n === 1'b0) begin
                reached = 1'b1;
                break;
            end
        end
        checkVal("rst_reach_ack", {31'd0, reached}, 32'd1);
        #2 rstN = 1'b0;
        #1;
        checkVal("rst_dtack", {31'd0, bus.M68K_DTACK_n}, 32'd1);
        checkVal("rst_berr",  {31'd0, bus.M68K_BERR_n},  32'd1);
        checkVal("rst_oe",    {31'd0, bus.M68K_D_OE},    32'd0);
        checkVal("rst_dout",  {16'd0, bus.M68K_D_OUT},   32'd0);
        checkVal("rst_ipl",   {29'd0, bus.M68K_IPL_n},   32'd7);
        bus.M68K_AS_n  = 1'b1;
        bus.M68K_UDS_n = 1'b1;
        bus.M68K_LDS_n = 1'b1;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus("post_rst_id", 24'hE80000, 3'b110, 1'b1, 1'b0, 1'b0, 16'h0000, TERM_ACK, 16'h5053, 1'b1, ACK_LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
